// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

   // Read-steering state: which port receives mem_rdata this cycle
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CPU  = 2'd1,
      RD_HOST = 2'd2
   } rd_state_e;

   // Port indices, also used as the value of the last-grant pointer
   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   // Default number of consecutive lost cycles before a grant is forced
   localparam int STARVE_LIMIT_DEF = 4;

   // Wait counter width; wide enough for the largest legal limit (15)
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: per-port count of consecutive lost arbitration cycles, saturating at LIMIT.
// Latency: starved_o reflects the registered count, so a new starvation is seen the cycle after the last loss.
// Backpressure: none; clears whenever the port is granted or drops its request.
module arb_wait_counter #(
   parameter int LIMIT = 4,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic gnt_i,
   output logic starved_o
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on grant or idle, otherwise count losses up to the limit
   always_comb begin
      cnt_d = cnt_q;
      if (!req_i || gnt_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT_C) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starved_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a CPU port and a host/debug port.
// Latency: grant is combinational in the request cycle; read data returns exactly one cycle after grant.
// Backpressure: a losing port gets no grant (CPU sees cpu_stall) and holds its request; starvation forces a grant.
// Build option DMEM_ARBITER_RR_EN: round-robin base policy; undefined gives fixed CPU priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   // Host/debug port
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   // Memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   rd_state_e state_q;
   rd_state_e state_d;

   logic cpu_starved;
   logic host_starved;
   logic cpu_win;
   logic host_win;
   logic base_cpu_wins;

   arb_wait_counter #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (WAIT_CNT_W)
   ) u_cpu_wait (
      .clk       (clk),
      .rst       (rst),
      .req_i     (cpu_req),
      .gnt_i     (cpu_gnt),
      .starved_o (cpu_starved)
   );

   arb_wait_counter #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (WAIT_CNT_W)
   ) u_host_wait (
      .clk       (clk),
      .rst       (rst),
      .req_i     (host_req),
      .gnt_i     (host_gnt),
      .starved_o (host_starved)
   );

`ifdef DMEM_ARBITER_RR_EN
   logic last_q;
   logic last_d;

   // Round-robin: the port that was not granted most recently wins a plain tie
   assign base_cpu_wins = (last_q == PORT_HOST);

   // Pointer follows every grant
   always_comb begin
      last_d = last_q;
      if (cpu_gnt) begin
         last_d = PORT_CPU;
      end else if (host_gnt) begin
         last_d = PORT_HOST;
      end
   end

   // Pointer register; starts at HOST so the CPU wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT_HOST;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: the CPU wins a plain tie
   assign base_cpu_wins = 1'b1;
`endif

   // Grant selection: starvation guard first (host wins if both starved), then base policy
   always_comb begin
      cpu_win  = 1'b0;
      host_win = 1'b0;
      if (cpu_req && host_req) begin
         if (host_starved) begin
            host_win = 1'b1;
         end else if (cpu_starved) begin
            cpu_win = 1'b1;
         end else if (base_cpu_wins) begin
            cpu_win = 1'b1;
         end else begin
            host_win = 1'b1;
         end
      end else begin
         cpu_win  = cpu_req;
         host_win = host_req;
      end
   end

   // Reset masks every combinational output so the block is silent immediately
   assign cpu_gnt   = cpu_win  & ~rst;
   assign host_gnt  = host_win & ~rst;
   assign cpu_stall = cpu_req  & ~cpu_gnt & ~rst;

   // Memory request mux, all zero when nobody is granted
   always_comb begin
      mem_en    = cpu_gnt | host_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   // Read steering: remember which port owns next cycle's mem_rdata, and route it there
   always_comb begin
      state_d     = IDLE;
      cpu_rvalid  = 1'b0;
      cpu_rdata   = '0;
      host_rvalid = 1'b0;
      host_rdata  = '0;
      if (cpu_gnt && !cpu_we) begin
         state_d = RD_CPU;
      end else if (host_gnt && !host_we) begin
         state_d = RD_HOST;
      end
      case (state_q)
         RD_CPU: begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_rdata;
         end
         RD_HOST: begin
            host_rvalid = 1'b1;
            host_rdata  = mem_rdata;
         end
         default: ;
      endcase
   end

   // Steering state register; reset drops any read in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the data-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost cycles that forces a grant; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have CPU request ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W.
REQ-007 SHALL have CPU response ports: cpu_gnt out 1, cpu_stall out 1, cpu_rvalid out 1, cpu_rdata out DATA_W.
REQ-008 SHALL have host/debug request ports: host_req in 1, host_we in 1, host_addr in ADDR_W, host_wdata in DATA_W.
REQ-009 SHALL have host/debug response ports: host_gnt out 1, host_rvalid out 1, host_rdata out DATA_W.
REQ-010 SHALL have memory ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W.
REQ-011 mem_rdata SHALL be valid one cycle after an mem_en=1, mem_we=0 access.

Function
REQ-012 Grant SHALL be combinational in the request cycle: at most one of cpu_gnt or host_gnt per cycle, and only to a requesting port.
REQ-013 A requester SHALL hold its req, we, addr and wdata stable until gnt; the arbiter is not required to handle changes before gnt.
REQ-014 mem_en SHALL equal (cpu_gnt | host_gnt); mem_we, mem_addr and mem_wdata SHALL be muxed from the granted port, and SHALL be 0 when neither port is granted.
REQ-015 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-016 The read-steering FSM SHALL have states IDLE, RD_CPU and RD_HOST.
REQ-017 FSM next state: RD_CPU after a granted CPU read; RD_HOST after a granted host read; IDLE otherwise.
REQ-018 The FSM SHALL accept back-to-back reads every cycle, with no bubble.
REQ-019 In RD_CPU, cpu_rvalid SHALL be 1 and cpu_rdata SHALL equal mem_rdata; in RD_HOST, the same SHALL apply on the host side.
REQ-020 Otherwise rvalid SHALL be 0 and rdata SHALL be 0.
REQ-021 Writes SHALL produce no rvalid.
REQ-022 Read latency SHALL be exactly 1 cycle from gnt to rvalid.
REQ-023 Each port SHALL have a wait counter: +1 on a cycle with req=1 and gnt=0, saturating at STARVE_LIMIT.
REQ-024 The wait counter SHALL clear on gnt or when req=0.
REQ-025 Tiebreak precedence when both ports request: (1) a port whose wait counter equals STARVE_LIMIT wins; (2) if both are starved, the host wins; (3) otherwise the base policy applies (REQ-031/032).
REQ-026 A single requester SHALL always be granted in the same cycle.
REQ-027 A write granted in cycle N SHALL be visible to a read granted in cycle N+1 or later, from either port.

Reset
REQ-028 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE, both wait counters SHALL be 0, and the last-grant pointer SHALL be HOST.
REQ-029 Assertion of rst SHALL take effect immediately, without waiting for clk.
REQ-030 A read in flight when rst asserts SHALL be discarded: no rvalid after rst deasserts.

Configuration
REQ-031 With macro DMEM_ARBITER_RR_EN defined, the base policy SHALL be round-robin: the port not in the last-grant pointer wins; the pointer updates on every grant.
REQ-032 Without DMEM_ARBITER_RR_EN, the base policy SHALL be fixed CPU priority; the last-grant pointer is not built; the starvation guard (REQ-025) remains active.

Structure
REQ-033 Shared package dmem_arb_pkg SHALL hold the FSM state encoding (IDLE, RD_CPU, RD_HOST), port indices PORT_CPU=0 and PORT_HOST=1, and a default STARVE_LIMIT constant.
REQ-034 The per-port saturating wait counter SHALL be a sub-module arb_wait_counter, instantiated twice.

Verification
REQ-035 Reset test: rst pulsed mid-cycle with cpu_req=1 -> all outputs 0 immediately; after release, cpu_gnt=1 on the first cycle.
REQ-036 Pipelined reads: CPU reads 0x010 then 0x011 on consecutive cycles, memory holds 0xA5A5_0001 and 0xA5A5_0002 -> cpu_rvalid high for 2 cycles, data in order, no stall.
REQ-037 Contention: both ports read every cycle for 8 cycles, then check grant sequence.
  - RR build: strict alternation C,H,C,H,...
  - Fixed build: grants C,C,C,C,H with STARVE_LIMIT=4.
REQ-038 Write/read interleave: host writes 0xDEAD_BEEF to 0x3FF in cycle N; CPU reads 0x3FF in cycle N+1 -> cpu_rdata=0xDEAD_BEEF in N+2; host_rvalid stays 0.
REQ-039 Reset during a read: rst asserted in the cycle after a host read grant -> host_rvalid never asserts; FSM is IDLE after release.
REQ-040 Counter clear: host_req dropped at wait count 3 and reasserted -> counter restarts from 0; no forced grant before 4 more lost cycles.
